ram2e_cfg_seq: RTL and testbench

//  Configuration sequencer for the RAM2E DRAM datapath. Watches Apple II writes to the
//  $C07x soft-switch page and owns the bank register (xx73 writes). Decodes a keyed

---
 rtl/ram2e_pkg.sv | 45 ++++
 rtl/ram2e_key_match.sv | 89 ++++++++
 rtl/ram2e_cfg_seq.sv | 93 +++++++++
 tb/tb_ram2e_cfg_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram2e_pkg.sv
// Shared definitions for the RAM2E configuration sequencer: key bytes,
// opcodes, key-matcher states and the refresh-period default.
package ram2e_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_K1,
        ST_K2,
        ST_K3,
        ST_K4,
        ST_K5,
        ST_CMD,
        ST_ARG
    } key_state_t;

    localparam logic [7:0] KEY0 = 8'hFF;
    localparam logic [7:0] KEY1 = 8'h00;
    localparam logic [7:0] KEY2 = 8'h55;
    localparam logic [7:0] KEY3 = 8'hAA;
    localparam logic [7:0] KEY4 = 8'hC1;
    localparam logic [7:0] KEY5 = 8'hAD;

    localparam logic [7:0] OP_REF  = 8'h10;
    localparam logic [7:0] OP_MASK = 8'h20;
    localparam logic [7:0] OP_LED  = 8'h30;

    localparam logic [3:0] REF_DEF = 4'd12;

    // Byte expected next while walking the key; CMD/ARG accept any byte
    function automatic logic [7:0] key_byte(input key_state_t s);
        case (s)
            ST_K1:   return KEY1;
            ST_K2:   return KEY2;
            ST_K3:   return KEY3;
            ST_K4:   return KEY4;
            ST_K5:   return KEY5;
            default: return KEY0;
        endcase
    endfunction

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_REF) || (b == OP_MASK) || (b == OP_LED);
    endfunction

endpackage

// File: rtl/ram2e_key_match.sv
// Keyed byte-sequence matcher for xx72 writes. Walks FF,00,55,AA,C1,AD,
// then accepts an opcode byte and an argument byte. A stray FF restarts
// the key at K1. A partial sequence aborts after TIMEOUT_CYC cycles
// without an xx72 write; a write landing on the abort cycle wins.
module ram2e_key_match #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_wr,
    input  logic [7:0] d,
    input  logic       op_known,
    output logic       op_stb,
    output logic       exec_stb
);
    import ram2e_pkg::*;

    // Timer value on the cycle that would make it reach TIMEOUT_CYC
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    key_state_t  state_q, state_d;
    logic [15:0] timer_q, timer_d;

    function automatic key_state_t next_key(input key_state_t s);
        case (s)
            ST_IDLE: return ST_K1;
            ST_K1:   return ST_K2;
            ST_K2:   return ST_K3;
            ST_K3:   return ST_K4;
            ST_K4:   return ST_K5;
            default: return ST_CMD;
        endcase
    endfunction

    // State and timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state, timer update and command strobes
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        op_stb   = 1'b0;
        exec_stb = 1'b0;
        if (key_wr) begin
            timer_d = '0;
            case (state_q)
                ST_CMD: begin
                    if (op_known) begin
                        state_d = ST_ARG;
                        op_stb  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARG: begin
                    state_d  = ST_IDLE;
                    exec_stb = 1'b1;
                end
                default: begin
                    if (d == key_byte(state_q)) begin
                        state_d = next_key(state_q);
                    end else if (d == KEY0) begin
                        state_d = ST_K1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TO_LAST) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else if (timer_q != 16'hFFFF) begin
                timer_d = timer_q + 16'd1;
            end
        end else begin
            timer_d = '0;
        end
    end

endmodule

// File: rtl/ram2e_cfg_seq.sv
// RAM2E configuration sequencer. Owns the bank register (xx73 writes) and
// the refresh period, bank mask and LED enable set through the keyed
// command sequence on xx72. All outputs are registered.
module ram2e_cfg_seq #(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter logic [3:0]  REF_DEF     = ram2e_pkg::REF_DEF,
    parameter logic [4:0]  MASK_DEF    = 5'h1F
) (
    input  logic       C14M,
    input  logic       Reset,
    input  logic       WrStb,
    input  logic       Sel73,
    input  logic       Sel72,
    input  logic [7:0] D,
    output logic [4:0] BA,
    output logic [3:0] RefMax,
    output logic [4:0] BankMask,
    output logic       LEDEn,
    output logic       CmdDone
);
    import ram2e_pkg::*;

    logic       bank_wr;
    logic       key_wr;
    logic       op_stb;
    logic       exec_stb;
    logic [7:0] op_q;

    // Sel73 wins when both selects are high
    assign bank_wr = WrStb & Sel73;
    assign key_wr  = WrStb & Sel72 & ~Sel73;

    // A zero refresh terminal value would stall refresh; force at least 1
    function automatic logic [3:0] ref_clamp(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    ram2e_key_match #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_key_match (
        .clk      (C14M),
        .rst      (Reset),
        .key_wr   (key_wr),
        .d        (D),
        .op_known (is_opcode(D)),
        .op_stb   (op_stb),
        .exec_stb (exec_stb)
    );

    // Opcode latch, loaded on the byte following the key
    always_ff @(posedge C14M) begin
        if (Reset) begin
            op_q <= '0;
        end else if (op_stb) begin
            op_q <= D;
        end
    end

    // Config registers: bank writes and opcode execution
    always_ff @(posedge C14M) begin
        if (Reset) begin
            BA       <= '0;
            RefMax   <= REF_DEF;
            BankMask <= MASK_DEF;
            LEDEn    <= 1'b1;
            CmdDone  <= 1'b0;
        end else begin
            CmdDone <= 1'b0;
            if (bank_wr) begin
                BA <= D[4:0] & BankMask;
            end
            if (exec_stb) begin
                case (op_q)
                    OP_REF: begin
                        RefMax  <= ref_clamp(D[3:0]);
                        CmdDone <= 1'b1;
                    end
                    OP_MASK: begin
                        BankMask <= D[4:0];
                        BA       <= BA & D[4:0];
                        CmdDone  <= 1'b1;
                    end
                    OP_LED: begin
                        LEDEn   <= D[0];
                        CmdDone <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram2e_cfg_seq.sv
// Testbench for ram2e_cfg_seq: directed stimulus, a reference model that
// queues the expected outputs for every clock, and explicit spot checks.
module tb_ram2e_cfg_seq;

    localparam int TO = 200;
    localparam logic [7:0] KEYS [6] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};

    logic       C14M = 1'b0;
    logic       Reset = 1'b1;
    logic       WrStb = 1'b0;
    logic       Sel73 = 1'b0;
    logic       Sel72 = 1'b0;
    logic [7:0] D = 8'h00;
    logic [4:0] BA;
    logic [3:0] RefMax;
    logic [4:0] BankMask;
    logic       LEDEn;
    logic       CmdDone;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0] ba;
        logic [3:0] rf;
        logic [4:0] mk;
        logic       led;
        logic       done;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [4:0] m_ba;
    logic [3:0] m_ref;
    logic [4:0] m_mask;
    logic       m_led;
    logic       m_done;
    int         m_idx;
    int         m_idle;
    logic [7:0] m_op;

    ram2e_cfg_seq #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .C14M     (C14M),
        .Reset    (Reset),
        .WrStb    (WrStb),
        .Sel73    (Sel73),
        .Sel72    (Sel72),
        .D        (D),
        .BA       (BA),
        .RefMax   (RefMax),
        .BankMask (BankMask),
        .LEDEn    (LEDEn),
        .CmdDone  (CmdDone)
    );

    always #5 C14M = ~C14M;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic w, input logic s3, input logic s2,
                         input logic [7:0] d);
        if (r) begin
            m_ba = 5'h00; m_ref = 4'd12; m_mask = 5'h1F; m_led = 1'b1; m_done = 1'b0;
            m_idx = 0; m_idle = 0; m_op = 8'h00;
        end else begin
            m_done = 1'b0;
            if (w && s3) m_ba = d[4:0] & m_mask;
            if (w && s2 && !s3) begin
                m_idle = 0;
                if (m_idx == 7) begin
                    if (m_op == 8'h10) begin
                        m_ref = (d[3:0] == 4'd0) ? 4'd1 : d[3:0];
                        m_done = 1'b1;
                    end else if (m_op == 8'h20) begin
                        m_mask = d[4:0];
                        m_ba = m_ba & d[4:0];
                        m_done = 1'b1;
                    end else if (m_op == 8'h30) begin
                        m_led = d[0];
                        m_done = 1'b1;
                    end
                    m_idx = 0;
                end else if (m_idx == 6) begin
                    if (d == 8'h10 || d == 8'h20 || d == 8'h30) begin
                        m_op = d;
                        m_idx = 7;
                    end else begin
                        m_idx = 0;
                    end
                end else if (d == KEYS[m_idx]) begin
                    m_idx = m_idx + 1;
                end else begin
                    m_idx = (d == 8'hFF) ? 1 : 0;
                end
            end else if (m_idx != 0) begin
                m_idle = m_idle + 1;
                if (m_idle == TO) begin
                    m_idx = 0;
                    m_idle = 0;
                end
            end
        end
        sb.push_back('{ba: m_ba, rf: m_ref, mk: m_mask, led: m_led, done: m_done});
    endtask

    // One clock: drive inputs, queue expectation, sample #1 after the edge
    task automatic cyc(input logic r, input logic w, input logic s3, input logic s2,
                       input logic [7:0] d);
        exp_t e;
        Reset = r; WrStb = w; Sel73 = s3; Sel72 = s2; D = d;
        model(r, w, s3, s2, d);
        @(posedge C14M);
        #1;
        e = sb.pop_front();
        chk("ba", {3'b0, BA}, {3'b0, e.ba});
        chk("refmax", {4'b0, RefMax}, {4'b0, e.rf});
        chk("bankmask", {3'b0, BankMask}, {3'b0, e.mk});
        chk("leden", {7'b0, LEDEn}, {7'b0, e.led});
        chk("cmddone", {7'b0, CmdDone}, {7'b0, e.done});
    endtask

    task automatic key(input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic bank(input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic prefix();
        for (int i = 0; i < 6; i++) key(KEYS[i]);
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        chk("rst_ba", {3'b0, BA}, 8'h00);
        chk("rst_refmax", {4'b0, RefMax}, 8'd12);
        chk("rst_mask", {3'b0, BankMask}, 8'h1F);
        chk("rst_led", {7'b0, LEDEn}, 8'h01);
        chk("rst_done", {7'b0, CmdDone}, 8'h00);
        idle(2);

        // Bank write
        bank(8'h1B);
        chk("t1_ba", {3'b0, BA}, 8'h1B);

        // Refresh period command
        prefix();
        key(8'h10);
        chk("t2_nodone_early", {7'b0, CmdDone}, 8'h00);
        key(8'h07);
        chk("t2_done", {7'b0, CmdDone}, 8'h01);
        chk("t2_refmax", {4'b0, RefMax}, 8'h07);
        idle(1);
        chk("t2_done_once", {7'b0, CmdDone}, 8'h00);

        // Bank mask: BA=1F, then mask 03 narrows BA, then masked bank write
        bank(8'h1F);
        prefix(); key(8'h20); key(8'h03);
        chk("t3_ba_exec", {3'b0, BA}, 8'h03);
        chk("t3_mask", {3'b0, BankMask}, 8'h03);
        bank(8'h1C);
        chk("t3_ba_masked", {3'b0, BA}, 8'h00);
        bank(8'h1F);
        chk("t3_ba_1f", {3'b0, BA}, 8'h03);

        // FF restart
        key(8'hFF); key(8'h00); key(8'hFF); key(8'h00); key(8'h55);
        key(8'hAA); key(8'hC1); key(8'hAD); key(8'h30); key(8'h00);
        chk("t4_led", {7'b0, LEDEn}, 8'h00);

        // Timeout: exact TO idle cycles aborts
        key(8'hFF); key(8'h00); key(8'h55);
        idle(TO);
        key(8'hAA); key(8'hC1); key(8'hAD); key(8'h10); key(8'h03);
        chk("t5_refmax", {4'b0, RefMax}, 8'h07);

        // Timeout boundary: write on the abort cycle still advances
        key(8'hFF); key(8'h00); key(8'h55);
        idle(TO - 1);
        key(8'hAA); key(8'hC1); key(8'hAD); key(8'h10); key(8'h09);
        chk("t5_boundary", {4'b0, RefMax}, 8'h09);

        // Clamp RefMax 0 to 1
        prefix(); key(8'h10); key(8'h00);
        chk("clamp", {4'b0, RefMax}, 8'h01);

        // Unknown opcode aborts; following bytes do nothing
        prefix(); key(8'h77); key(8'h10); key(8'h05);
        chk("badop", {4'b0, RefMax}, 8'h01);

        // Both selects: treated as bank write, key does not advance
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        key(8'h00); key(8'h55); key(8'hAA); key(8'hC1); key(8'hAD); key(8'h30); key(8'h01);
        chk("both_sel_led", {7'b0, LEDEn}, 8'h00);

        // Reset mid-sequence
        key(8'hFF); key(8'h00); key(8'h55); key(8'hAA); key(8'hC1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_rst_mask", {3'b0, BankMask}, 8'h1F);
        chk("t6_rst_refmax", {4'b0, RefMax}, 8'd12);
        key(8'hAD); key(8'h10); key(8'h03);
        chk("t6_no_effect", {4'b0, RefMax}, 8'd12);

        // Bank write mid-sequence; sequence still completes
        key(8'hFF); key(8'h00);
        bank(8'h15);
        key(8'h55); key(8'hAA); key(8'hC1); key(8'hAD); key(8'h10); key(8'h04);
        chk("t6_ba_mid", {3'b0, BA}, 8'h15);
        chk("t6_ref_mid", {4'b0, RefMax}, 8'h04);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
